// File: rtl/rom_responder_pkg.sv
// Shared definitions for the program-memory responder: bus phase numbering,
// nibble/byte widths and the phase-advance rule.
package rom_responder_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int BYTE_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int CYCLE_LEN = 8;

  // A1..X3 are numbered 0..7 to match the CPU's own phase counter.
  typedef enum logic [3:0] {
    PH_A1   = 4'd0,
    PH_A2   = 4'd1,
    PH_A3   = 4'd2,
    PH_M1   = 4'd3,
    PH_M2   = 4'd4,
    PH_X1   = 4'd5,
    PH_X2   = 4'd6,
    PH_X3   = 4'd7,
    PH_IDLE = 4'd8
  } phase_e;

  localparam phase_e PH_DRIVE_HI = PH_M1;
  localparam phase_e PH_DRIVE_LO = PH_M2;

  function automatic phase_e next_phase(input phase_e ph, input logic sync);
    phase_e nxt;
    if (sync) begin
      nxt = PH_A1;
    end else begin
      case (ph)
        PH_IDLE, PH_X3: nxt = PH_IDLE;
        default:        nxt = phase_e'(ph + 4'd1);
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rom_responder_store.sv
// 256x8 program store: one synchronous write port, one asynchronous read port.
module rom_store
  import rom_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Contents survive reset; a loader may write at any time.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rom_responder.sv
// Instruction-fetch responder: follows the CPU bus phases from sync, captures
// the fetch address and returns the addressed byte as two nibbles in M1/M2.
module rom_responder
  import rom_responder_pkg::*;
#(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter int         DEPTH   = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NIBBLE_W-1:0] data_i,
  input  logic                sync,
  input  logic                rom_cmd,
  output logic [NIBBLE_W-1:0] data_o,
  output logic                data_en,
  output logic                selected,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [BYTE_W-1:0]   prog_data
);

  phase_e              phase;
  phase_e              phase_nxt;
  logic [NIBBLE_W-1:0] addr_lo;
  logic [NIBBLE_W-1:0] addr_hi;
  logic [BYTE_W-1:0]   opcode;
  logic [BYTE_W-1:0]   rd_byte;
  logic                sel_now;

  rom_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clock (clock),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr ({addr_hi, addr_lo}),
    .rdata (rd_byte)
  );

  always_comb begin
    phase_nxt = next_phase(phase, sync);
    sel_now   = rom_cmd && (data_i == CHIP_ID);
  end

  // The read is asynchronous, so a same-edge program write is not yet visible
  // when the A3 edge samples rd_byte: the fetch sees the old contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase    <= PH_IDLE;
      addr_lo  <= '0;
      addr_hi  <= '0;
      opcode   <= '0;
      data_o   <= '0;
      data_en  <= 1'b0;
      selected <= 1'b0;
    end else begin
      phase <= phase_nxt;

      if (phase == PH_A1) addr_lo <= data_i;
      if (phase == PH_A2) addr_hi <= data_i;
      if (phase == PH_A3 && sel_now) opcode <= rd_byte;

      if (phase_nxt == PH_DRIVE_HI)
        selected <= sel_now;
      else if (phase_nxt == PH_A1 || phase_nxt == PH_IDLE)
        selected <= 1'b0;

      // Outputs are computed for the phase being entered, so they are valid
      // from the edge that starts M1 and M2 and drop at the edge starting X1.
      data_o  <= '0;
      data_en <= 1'b0;
      if (phase_nxt == PH_DRIVE_HI && sel_now) begin
        data_o  <= rd_byte[BYTE_W-1:NIBBLE_W];
        data_en <= 1'b1;
      end else if (phase_nxt == PH_DRIVE_LO && selected) begin
        data_o  <= opcode[NIBBLE_W-1:0];
        data_en <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rom_responder.md
# rom_responder

Program-memory responder for the 4-bit bus CPU: the other end of the CPU's instruction-fetch interface. It tracks the CPU's 8-phase bus cycle from `sync`, captures the 12-bit fetch address nibble by nibble, and drives the addressed 8-bit instruction back onto the 4-bit bus during M1/M2 when its chip number is selected. It sits at top level beside the CPU, taking the CPU's `data_o`/`sync`/`rom_cmd` as inputs. Program contents are written through a side-band load port by the bench or a loader.

## Interface
Parameters:
- `CHIP_ID`, default 4'h0: chip number matched against the A3 address nibble.
- `DEPTH`, default 256: bytes of program store. Fixed 256; the address is `{A2,A1}`.

Ports:
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `data_i`  in  4  CPU bus output (CPU `data_o`).
- `sync`  in  1  CPU sync; high in the X3 cycle that precedes A1.
- `rom_cmd`  in  1  CPU ROM command; qualifies chip select in A3.
- `data_o`  out  4  instruction nibble to the CPU (CPU `data_i`).
- `data_en`  out  1  high while `data_o` is valid and driven.
- `selected`  out  1  high from M1 through X3 of a cycle this chip answered.
- `prog_we`  in  1  program-store write strobe.
- `prog_addr`  in  8  program-store write address.
- `prog_data`  in  8  program-store write data.

## Operation
- Phase tracker states: IDLE, A1, A2, A3, M1, M2, X1, X2, X3.
- Phase transitions:
  - Any state with `sync`=1 goes to A1 next cycle. This includes an unexpected `sync`, which forces resync.
  - Otherwise A1→A2→…→X3 advances one step per clock.
  - X3 with `sync`=0 goes to IDLE.
  - IDLE with `sync`=0 stays in IDLE.
- Address capture:
  - Clock edge ending A1: latch `data_i` as addr[3:0].
  - Clock edge ending A2: latch `data_i` as addr[7:4].
- Select decision, at the clock edge ending A3:
  - sel = `rom_cmd` && (`data_i` == `CHIP_ID`).
  - If sel: latch the whole byte mem[{addr[7:4], addr[3:0]}] into the opcode register, and set `selected`.
  - If not sel: the opcode register is unchanged and `selected` is cleared.
- Drive:
  - In M1, when selected: `data_o` = opcode[7:4], `data_en` = 1.
  - In M2, when selected: `data_o` = opcode[3:0], `data_en` = 1.
  - In all other phases, or when not selected: `data_o` = 0, `data_en` = 0.
- Program store: 256×8, asynchronous read, synchronous write on `prog_we`.
  - A write on the same edge as the A3 latch: the fetch gets the old contents.
  - Writes during M1/M2 do not affect the in-flight opcode.
  - Writes are accepted in every phase, including during reset.
- Reset values:
  - Phase = IDLE; `data_o` = 0; `data_en` = 0; `selected` = 0.
  - Address and opcode registers = 0.
  - The program store is not cleared.
- Reset mid-cycle: outputs drop at the next edge. The responder ignores the bus until the next `sync`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `sync` high at edge t puts the tracker in A1 during cycle t+1. A1 is the 1st cycle after `sync`; M1 is the 4th and M2 the 5th.
- `data_en`/`data_o` become valid at the edge starting M1 and hold exactly 2 cycles (M1, M2). They fall at the edge starting X1.
- Latency from the A3 nibble to the first instruction nibble is 1 cycle.
- Back-to-back cycles: `sync` in X3 then A1 gives continuous 8-cycle fetches with no bubble.
- `selected` rises at the edge starting M1 and falls at the edge starting A1 (or IDLE).

## Structure
- Shared package contents:
  - Phase enum (IDLE, A1..X3).
  - Nibble and byte widths.
  - Phase constants shared with the CPU (the cycle numbering must match the CPU's own phase counter).
- One sub-module: `rom_store`, a 256×8 array with one synchronous write port and one asynchronous read port.
- The phase tracker, address/opcode capture and output drive live in the top body.

## Test plan
- Load mem[8'h00]=8'hD5 and mem[8'h01]=8'h2A. Drive a fetch with A1=0, A2=0, A3=0 and `rom_cmd`=1. Required: M1 gives `data_o`=4'hD, M2 gives `data_o`=4'h5, `data_en` is high exactly 2 cycles, and `selected` goes high.
- With `CHIP_ID`=4'h3, fetch with A3=4'h2, then with A3=4'h3 (address 8'h01). Required: no drive on the first fetch; 4'h2 then 4'hA on the second.
- Fetch with A3 matching but `rom_cmd`=0. Required: `data_en` stays 0 for all 8 phases.
- Run back-to-back cycles at addresses 8'h00, 8'h01, 8'hFF with `sync` every 8th cycle. Required: correct nibbles each cycle; the 8'hFF fetch wraps nothing and reads mem[255].
- Write mem[8'h10]=8'h77 on the A3 edge of a fetch to 8'h10 holding the old value 8'h11. Required: drives 1,1; the next fetch drives 7,7.
- Assert `reset` during M1. Required: `data_en`=0 at the next edge and stays IDLE with no drive. Omit `sync` at X3. Required: IDLE, and the next `sync` resumes a correct fetch.
